// File: rtl/endat22_slave_emu_pkg.sv
// -----------------------------------------------------------------------------
// endat_pkg
// Shared definitions for the EnDat 2.2 slave emulator and, later, the master.
//   MODE_POS_READ  : mode command answered with a position frame
//   CRC_POLY_DEF   : low bits of the CRC-5 generator x^5+x^3+x+1
//   CRC_INIT       : CRC preset loaded at the start of every frame
//   POS_MAX        : width of the position source bus
//   endat_state_t  : FSM state encoding (legacy-compatible constants)
//   crc5_step()    : one serial CRC-5 update for a single data bit
// -----------------------------------------------------------------------------
package endat_pkg;

    localparam logic [5:0] MODE_POS_READ = 6'b000111;
    localparam logic [4:0] CRC_POLY_DEF  = 5'b01011;
    localparam logic [4:0] CRC_INIT      = 5'b11111;
    localparam int         POS_MAX       = 26;

    typedef logic [3:0] endat_state_t;

    localparam endat_state_t ST_IDLE   = 4'd0;
    localparam endat_state_t ST_T_WAIT = 4'd1;
    localparam endat_state_t ST_MODE   = 4'd2;
    localparam endat_state_t ST_CALC   = 4'd3;
    localparam endat_state_t ST_START  = 4'd4;
    localparam endat_state_t ST_ALARM  = 4'd5;
    localparam endat_state_t ST_POS    = 4'd6;
    localparam endat_state_t ST_CRC    = 4'd7;
    localparam endat_state_t ST_RECOV  = 4'd8;

    // Feedback is the outgoing MSB xor the new data bit.
    function automatic logic [4:0] crc5_step(input logic [4:0] crc,
                                             input logic       din,
                                             input logic [4:0] poly);
        logic fb;
        fb = crc[4] ^ din;
        return {crc[3:0], 1'b0} ^ (fb ? poly : 5'b00000);
    endfunction

endpackage

// File: rtl/endat22_slave_emu_if.sv
// -----------------------------------------------------------------------------
// endat22_slave_emu_if
// EnDat line bundle between position master and encoder (slave).
//   clk_en    : master clock burst active (0 = line idle)
//   enc_wr    : direction, 1 = master drives mode bits
//   enc_tdata : mode bit from master, valid when enc_wr = 1
//   enc_data  : data line from slave to master, idle high
// -----------------------------------------------------------------------------
interface endat22_slave_emu_if;

    logic clk_en;
    logic enc_wr;
    logic enc_tdata;
    logic enc_data;

    modport master (
        output clk_en,
        output enc_wr,
        output enc_tdata,
        input  enc_data
    );

    modport slave (
        input  clk_en,
        input  enc_wr,
        input  enc_tdata,
        output enc_data
    );

endinterface

// File: rtl/endat22_slave_emu_crc5.sv
// -----------------------------------------------------------------------------
// endat_crc5
// Serial CRC-5 LFSR. init presets to CRC_INIT, enable advances by one bit.
//   enc_clk  in  clock, rising edge
//   rst_n    in  asynchronous active-low reset (crc -> 0)
//   init     in  load preset (has priority over enable)
//   enable   in  absorb din this cycle
//   din      in  serial data bit
//   crc      out current remainder, crc[4] = highest-order bit
// -----------------------------------------------------------------------------
module endat_crc5
    import endat_pkg::*;
#(
    parameter logic [4:0] POLY = CRC_POLY_DEF
) (
    input  logic       enc_clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       enable,
    input  logic       din,
    output logic [4:0] crc
);

    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 5'b00000;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc5_step(crc, din, POLY);
        end
    end

endmodule

// File: rtl/endat22_slave_emu.sv
// -----------------------------------------------------------------------------
// endat22_slave_emu
// EnDat 2.2 encoder-side emulator. Receives the 6-bit mode command and, for
// "read position", answers with start bit, alarm, POS_BITS position bits LSB
// first and the inverted CRC-5, MSB first.
//   enc_clk     in   master's EnDat clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   bus         if   slave side of the EnDat line (clk_en/enc_wr/enc_tdata in,
//                    enc_data out)
//   pos_in      in   position source, bits [POS_BITS-1:0] used
//   alarm_in    in   alarm flag reported in the frame
//   busy        out  high from first clk_en cycle until back in IDLE
//   frame_done  out  1-cycle pulse after the last CRC bit
//   cmd_err     out  1-cycle pulse on an unsupported mode command
//   cmd_last    out  last received mode command
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle high, waiting for clk_en
// T_WAIT   | 2 cycles before the mode bits
// MODE     | shifting in 6 mode bits (enc_wr=1 cycles only)
// CALC     | enc_data low for CALC_CYC cycles (position calculation)
// START    | start bit (1)
// ALARM    | alarm bit, first bit into the CRC
// POS      | POS_BITS position bits, LSB first
// CRC      | 5 inverted CRC bits, MSB first
// RECOV    | enc_data low RECOV_CYC cycles, then high until clk_en drops
// -----------------------------------------------------------------------------
module endat22_slave_emu
    import endat_pkg::*;
#(
    parameter int         POS_BITS  = 19,
    parameter int         CALC_CYC  = 3,
    parameter int         RECOV_CYC = 8,
    parameter logic [4:0] CRC_POLY  = CRC_POLY_DEF
) (
    input  logic                enc_clk,
    input  logic                rst_n,
    endat22_slave_emu_if.slave  bus,
    input  logic [POS_MAX-1:0]  pos_in,
    input  logic                alarm_in,
    output logic                busy,
    output logic                frame_done,
    output logic                cmd_err,
    output logic [5:0]          cmd_last
);

    localparam int MAX_A   = (POS_BITS > CALC_CYC) ? POS_BITS : CALC_CYC;
    localparam int MAX_B   = (MAX_A > RECOV_CYC) ? MAX_A : RECOV_CYC;
    localparam int MAX_CNT = (MAX_B > 5) ? MAX_B : 5;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] TWAIT_LD = CNT_W'(1);
    localparam logic [CNT_W-1:0] CALC_LD  = CNT_W'(CALC_CYC - 1);
    localparam logic [CNT_W-1:0] POS_LD   = CNT_W'(POS_BITS - 1);
    localparam logic [CNT_W-1:0] CRC_LD   = CNT_W'(4);
    // RECOV loads the full count: the line reads 0 while cnt != 0, so the
    // low phase lasts exactly RECOV_CYC cycles before the terminal count.
    localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC);

    endat_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        mode_cnt;
    logic [5:0]        cmd_sr;
    // Frame payload with the alarm in bit 0 so a plain right shift emits
    // alarm first, then the position LSB first.
    logic [POS_BITS:0] sreg;
    logic [4:0]        crc;

    logic [5:0]        cmd_next;
    logic              mode_last;
    logic              cmd_ok;
    logic              abort;
    logic              crc_init;
    logic              crc_en;
    logic              crc_din;
    logic              cnt_zero;
    logic              unused_pos;

    assign cmd_next   = {cmd_sr[4:0], bus.enc_tdata};
    assign mode_last  = (state == ST_MODE) && bus.clk_en && bus.enc_wr &&
                        (mode_cnt == 3'd5);
    assign cmd_ok     = (cmd_next == MODE_POS_READ);
    assign abort      = !bus.clk_en && (state != ST_IDLE) && (state != ST_RECOV);
    assign cnt_zero   = (cnt == '0);
    assign busy       = (state != ST_IDLE);
    assign unused_pos = ^pos_in;

    // During CRC output the LFSR is reused as a plain left shifter: feeding
    // din = crc[4] cancels the feedback, leaving {crc[3:0],0}.
    assign crc_init = mode_last && cmd_ok;
    assign crc_en   = bus.clk_en &&
                      ((state == ST_ALARM) || (state == ST_POS) || (state == ST_CRC));
    assign crc_din  = (state == ST_CRC) ? crc[4] : sreg[0];

    endat_crc5 #(
        .POLY (CRC_POLY)
    ) u_crc (
        .enc_clk (enc_clk),
        .rst_n   (rst_n),
        .init    (crc_init),
        .enable  (crc_en),
        .din     (crc_din),
        .crc     (crc)
    );

    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mode_cnt   <= 3'd0;
            cmd_sr     <= 6'd0;
            sreg       <= '0;
            cmd_last   <= 6'd0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            if (abort) begin
                state <= ST_RECOV;
                cnt   <= RECOV_LD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.clk_en) begin
                            state    <= ST_T_WAIT;
                            cnt      <= TWAIT_LD;
                            mode_cnt <= 3'd0;
                        end
                    end
                    ST_T_WAIT: begin
                        if (cnt_zero) state <= ST_MODE;
                        else          cnt   <= cnt - 1'b1;
                    end
                    ST_MODE: begin
                        if (bus.enc_wr) begin
                            cmd_sr   <= cmd_next;
                            mode_cnt <= mode_cnt + 3'd1;
                            if (mode_last) begin
                                cmd_last <= cmd_next;
                                if (cmd_ok) begin
                                    state <= ST_CALC;
                                    cnt   <= CALC_LD;
                                    sreg  <= {pos_in[POS_BITS-1:0], alarm_in};
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= ST_RECOV;
                                    cnt     <= RECOV_LD;
                                end
                            end
                        end
                    end
                    ST_CALC: begin
                        if (cnt_zero) state <= ST_START;
                        else          cnt   <= cnt - 1'b1;
                    end
                    ST_START: begin
                        state <= ST_ALARM;
                    end
                    ST_ALARM: begin
                        sreg  <= {1'b0, sreg[POS_BITS:1]};
                        state <= ST_POS;
                        cnt   <= POS_LD;
                    end
                    ST_POS: begin
                        sreg <= {1'b0, sreg[POS_BITS:1]};
                        if (cnt_zero) begin
                            state <= ST_CRC;
                            cnt   <= CRC_LD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_CRC: begin
                        if (cnt_zero) begin
                            state      <= ST_RECOV;
                            cnt        <= RECOV_LD;
                            frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RECOV: begin
                        if (!cnt_zero)        cnt   <= cnt - 1'b1;
                        else if (!bus.clk_en) state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Line value is decoded from state so an async reset forces it high at once.
    always_comb begin
        bus.enc_data = 1'b1;
        case (state)
            ST_CALC:  bus.enc_data = 1'b0;
            ST_ALARM: bus.enc_data = sreg[0];
            ST_POS:   bus.enc_data = sreg[0];
            ST_CRC:   bus.enc_data = ~crc[4];
            ST_RECOV: bus.enc_data = cnt_zero;
            default:  bus.enc_data = 1'b1;
        endcase
    end

endmodule
